// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: bus operation codes, engine states
// and the mapping from a requested operation to the state that executes it.
package i2c_pkg;

    typedef enum logic [1:0] {
        INSTR_START = 2'd0,
        INSTR_STOP  = 2'd1,
        INSTR_READ  = 2'd2,
        INSTR_WRITE = 2'd3
    } InstrT;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STOP,
        READ,
        WRITE,
        DONE
    } StateT;

    function automatic StateT opState(input InstrT instr);
        case (instr)
            INSTR_START: opState = START;
            INSTR_STOP:  opState = STOP;
            INSTR_READ:  opState = READ;
            default:     opState = WRITE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Request/response and pad-side signals of the I2C master. The master modport
// is the engine's view; the slave modport is the sequencer/pad side.
interface i2c_master_if;
    import i2c_pkg::*;

    logic       sdaIn;
    logic       sdaOut;
    logic       isSending;
    logic       scl;
    InstrT      instruction;
    logic       enable;
    logic [7:0] byteToSend;
    logic [7:0] byteReceived;
    logic       complete;

    modport master (
        input  sdaIn, instruction, enable, byteToSend,
        output sdaOut, isSending, scl, byteReceived, complete
    );

    modport slave (
        output sdaIn, instruction, enable, byteToSend,
        input  sdaOut, isSending, scl, byteReceived, complete
    );

endinterface

// File: rtl/i2c_phase_timer.sv
// Divides the system clock into SCL half-periods. Tracks which half of a bit
// is running so the engine knows when the SCL-high half is about to end.
module i2c_phase_timer #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic phaseEnd,
    output logic lastHighCycle,
    output logic highHalf
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cycleCnt;

    assign phaseEnd      = run && (cycleCnt == LAST);
    assign lastHighCycle = phaseEnd && highHalf;

    // Every phase boundary flips the half flag; each bit starts in the low half.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cycleCnt <= '0;
            highHalf <= 1'b0;
        end else if (run) begin
            if (cycleCnt == LAST) begin
                cycleCnt <= '0;
                highHalf <= ~highHalf;
            end else begin
                cycleCnt <= cycleCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C engine: executes one START, STOP, READ or WRITE per
// enable/complete handshake and drives registered SCL and split SDA controls.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input logic          clk,
    input logic          rst,
    i2c_master_if.master bus
);

    StateT      state;
    logic       sclReg;
    logic       isSendingReg;
    logic       sdaOutReg;
    logic       completeReg;
    logic [7:0] rxByte;
    logic [7:0] txShift;
    logic [7:0] rxShift;
    logic       ackBit;
    logic [3:0] bitCnt;
    logic [1:0] phaseCnt;
    logic       opDone;

    logic phaseEnd;
    logic lastHighCycle;
    logic highHalf;
    logic timerRun;

    assign bus.scl          = sclReg;
    assign bus.isSending    = isSendingReg;
    assign bus.sdaOut       = sdaOutReg;
    assign bus.complete     = completeReg;
    assign bus.byteReceived = rxByte;

    assign timerRun = (state == START || state == STOP || state == READ || state == WRITE) && !opDone;

    i2c_phase_timer #(.CLK_DIV(CLK_DIV)) phaseTimer (
        .clk          (clk),
        .rst          (rst),
        .clear        (state == IDLE),
        .run          (timerRun),
        .phaseEnd     (phaseEnd),
        .lastHighCycle(lastHighCycle),
        .highHalf     (highHalf)
    );

    // Once the final phase has elapsed (opDone), the following edge applies the
    // exit levels and raises complete, so the op occupies exactly N+1 edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sclReg       <= 1'b1;
            isSendingReg <= 1'b0;
            sdaOutReg    <= 1'b1;
            completeReg  <= 1'b0;
            rxByte       <= 8'h00;
            txShift      <= 8'h00;
            rxShift      <= 8'h00;
            ackBit       <= 1'b0;
            bitCnt       <= 4'd0;
            phaseCnt     <= 2'd0;
            opDone       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        txShift  <= bus.byteToSend;
                        ackBit   <= bus.byteToSend[0];
                        rxShift  <= 8'h00;
                        bitCnt   <= 4'd0;
                        phaseCnt <= 2'd0;
                        opDone   <= 1'b0;
                        state    <= opState(bus.instruction);
                    end
                end

                START: begin
                    if (opDone) begin
                        sclReg       <= 1'b0;
                        isSendingReg <= 1'b1;
                        sdaOutReg    <= 1'b0;
                        completeReg  <= 1'b1;
                        state        <= DONE;
                    end else begin
                        sclReg       <= 1'b1;
                        isSendingReg <= (phaseCnt != 2'd0);
                        sdaOutReg    <= (phaseCnt == 2'd0);
                        if (phaseEnd) begin
                            if (phaseCnt == 2'd1) opDone <= 1'b1;
                            else                  phaseCnt <= phaseCnt + 2'd1;
                        end
                    end
                end

                STOP: begin
                    if (opDone) begin
                        sclReg       <= 1'b1;
                        isSendingReg <= 1'b0;
                        sdaOutReg    <= 1'b1;
                        completeReg  <= 1'b1;
                        state        <= DONE;
                    end else begin
                        sclReg       <= (phaseCnt != 2'd0);
                        isSendingReg <= (phaseCnt != 2'd2);
                        sdaOutReg    <= (phaseCnt == 2'd2);
                        if (phaseEnd) begin
                            if (phaseCnt == 2'd2) opDone <= 1'b1;
                            else                  phaseCnt <= phaseCnt + 2'd1;
                        end
                    end
                end

                // Data bit changes only together with the SCL-low edge; the slave
                // ACK is captured just before SCL falls on the ninth bit.
                WRITE: begin
                    if (opDone) begin
                        sclReg      <= 1'b0;
                        completeReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        sclReg <= highHalf;
                        if (bitCnt == 4'd8) begin
                            isSendingReg <= 1'b0;
                            sdaOutReg    <= 1'b1;
                        end else begin
                            isSendingReg <= 1'b1;
                            sdaOutReg    <= txShift[7];
                        end
                        if (lastHighCycle) begin
                            if (bitCnt == 4'd8) begin
                                rxByte <= {7'd0, bus.sdaIn};
                                opDone <= 1'b1;
                            end else begin
                                txShift <= {txShift[6:0], 1'b0};
                                bitCnt  <= bitCnt + 4'd1;
                            end
                        end
                    end
                end

                READ: begin
                    if (opDone) begin
                        sclReg      <= 1'b0;
                        completeReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        sclReg <= highHalf;
                        if (bitCnt == 4'd8) begin
                            isSendingReg <= 1'b1;
                            sdaOutReg    <= ackBit;
                        end else begin
                            isSendingReg <= 1'b0;
                            sdaOutReg    <= 1'b1;
                        end
                        if (lastHighCycle) begin
                            if (bitCnt == 4'd8) begin
                                rxByte <= rxShift;
                                opDone <= 1'b1;
                            end else begin
                                rxShift <= {rxShift[6:0], bus.sdaIn};
                                bitCnt  <= bitCnt + 4'd1;
                            end
                        end
                    end
                end

                DONE: begin
                    if (!bus.enable) begin
                        completeReg <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: open-drain SDA with a byte-level slave,
// directed vector table, randomized READ/WRITE ops against a reference model.
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int C = 4;

    typedef struct {
        InstrT      instr;
        logic [7:0] data;
        logic [7:0] sByte;
        logic       sAck;
        bit         dropEarly;
        int         holdHigh;
        logic [7:0] expRx;
        int         expEdges;
        logic       expScl;
        int         expRiseN;
        logic [8:0] expVec;
    } VecT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_if bus();

    i2c_master #(.CLK_DIV(C)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    // Slave side: counts SCL falls to know which bit of the byte is on the wire.
    logic       slaveActive = 1'b0;
    InstrT      slaveOp = INSTR_START;
    logic [7:0] slaveByte = 8'h00;
    logic       slaveAck = 1'b1;
    int         fallCount = 0;
    int         fallBase = 0;
    int         riseCount = 0;
    int         riseBase = 0;
    logic       riseQ[$];
    logic       slavePull;
    logic       sdaLine;

    always_comb begin
        int curBit;
        logic [7:0] sh;
        curBit = fallCount - fallBase;
        sh = slaveByte << curBit;
        slavePull = 1'b0;
        if (slaveActive && slaveOp == INSTR_WRITE && curBit == 8 && !slaveAck) slavePull = 1'b1;
        if (slaveActive && slaveOp == INSTR_READ && curBit >= 0 && curBit < 8 && !sh[7]) slavePull = 1'b1;
    end

    assign sdaLine   = !((bus.isSending && !bus.sdaOut) || slavePull);
    assign bus.sdaIn = sdaLine;

    always @(negedge bus.scl) fallCount = fallCount + 1;

    always @(posedge bus.scl) begin
        riseQ.push_back(sdaLine);
        riseCount = riseCount + 1;
    end

    // Watches for SDA moving while SCL stays high outside START/STOP.
    int   violations = 0;
    bit   allowEdge = 1'b1;
    bit   prevValid = 1'b0;
    logic prevScl;
    logic prevLine;

    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (prevValid && !allowEdge && prevScl && bus.scl && prevLine != sdaLine) violations++;
            prevValid = 1'b1;
        end
        prevScl  = bus.scl;
        prevLine = sdaLine;
    end

    int         resEdges;
    int         resRiseN;
    int         resFirstRxChange;
    logic [8:0] resVec;
    logic       resScl;
    bit         resHoldOk;
    bit         resCleared;
    logic       sclTrace[0:127];
    logic       lineTrace[0:127];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Issues one request, then scrambles instruction/data to prove they were latched.
    task automatic applyStimulus(input VecT v);
        logic [7:0] prevRx;
        bit         done;
        logic       holdLine;
        slaveOp     = v.instr;
        slaveByte   = v.sByte;
        slaveAck    = v.sAck;
        fallBase    = fallCount;
        riseBase    = riseCount;
        slaveActive = (v.instr == INSTR_READ || v.instr == INSTR_WRITE);
        allowEdge   = (v.instr == INSTR_START || v.instr == INSTR_STOP);
        prevRx      = bus.byteReceived;
        bus.instruction = v.instr;
        bus.byteToSend  = v.data;
        bus.enable      = 1'b1;
        @(posedge clk); #1;
        bus.instruction = InstrT'(~v.instr);
        bus.byteToSend  = ~v.data;
        if (v.dropEarly) bus.enable = 1'b0;
        resEdges = 0;
        resFirstRxChange = 0;
        done = 1'b0;
        while (!done && resEdges < 400) begin
            @(posedge clk); #1;
            resEdges++;
            if (resEdges < 128) begin
                sclTrace[resEdges]  = bus.scl;
                lineTrace[resEdges] = sdaLine;
            end
            if (resFirstRxChange == 0 && bus.byteReceived !== prevRx) resFirstRxChange = resEdges;
            done = bus.complete;
        end
        resRiseN = riseCount - riseBase;
        resVec = '0;
        for (int i = 0; i < resRiseN && i < 9; i++) resVec = {resVec[7:0], riseQ[riseBase + i]};
        resScl    = bus.scl;
        holdLine  = sdaLine;
        resHoldOk = 1'b1;
        for (int i = 0; i < v.holdHigh; i++) begin
            @(posedge clk); #1;
            if (!(bus.complete && bus.scl == resScl && sdaLine == holdLine)) resHoldOk = 1'b0;
        end
        bus.enable = 1'b0;
        @(posedge clk); #1;
        resCleared  = !bus.complete;
        slaveActive = 1'b0;
        allowEdge   = 1'b0;
    endtask

    task automatic runAndCheck(input VecT v, input string tag);
        applyStimulus(v);
        checkOutput({tag, ".edges"}, resEdges, v.expEdges);
        checkOutput({tag, ".rx"}, bus.byteReceived, v.expRx);
        checkOutput({tag, ".scl"}, resScl, v.expScl);
        checkOutput({tag, ".rises"}, resRiseN, v.expRiseN);
        checkOutput({tag, ".riseBits"}, resVec, v.expVec);
        checkOutput({tag, ".cleared"}, resCleared, 1);
        if (v.instr == INSTR_READ || v.instr == INSTR_WRITE)
            checkOutput({tag, ".rxTiming"}, (resFirstRxChange == 0 || resFirstRxChange == resEdges - 1), 1);
        if (v.holdHigh > 0)
            checkOutput({tag, ".holdNoNewOp"}, resHoldOk, 1);
        if (v.instr == INSTR_START)
            checkOutput({tag, ".startShape"}, {sclTrace[4], lineTrace[4], sclTrace[5], lineTrace[5]}, 4'b1110);
        if (v.instr == INSTR_STOP)
            checkOutput({tag, ".stopShape"}, {sclTrace[4], lineTrace[4], sclTrace[8], lineTrace[8],
                                              sclTrace[12], lineTrace[12]}, 6'b001011);
    endtask

    // Reference behaviour derived from bus-level rules: bit order, ACK meaning, op lengths.
    function automatic VecT modelOp(input InstrT instr, input logic [7:0] data, input logic [7:0] sByte,
                                    input logic sAck, input logic [7:0] lastRx);
        VecT v;
        v.instr = instr; v.data = data; v.sByte = sByte; v.sAck = sAck;
        v.dropEarly = 1'b0; v.holdHigh = 0;
        case (instr)
            INSTR_START: begin v.expRx = lastRx; v.expEdges = 1 + 2 * C; v.expScl = 1'b0; v.expRiseN = 0; v.expVec = '0; end
            INSTR_STOP:  begin v.expRx = lastRx; v.expEdges = 1 + 3 * C; v.expScl = 1'b1; v.expRiseN = 1; v.expVec = '0; end
            INSTR_WRITE: begin v.expRx = {7'd0, sAck}; v.expEdges = 1 + 9 * 2 * C; v.expScl = 1'b0; v.expRiseN = 9; v.expVec = {data, sAck}; end
            default:     begin v.expRx = sByte; v.expEdges = 1 + 9 * 2 * C; v.expScl = 1'b0; v.expRiseN = 9; v.expVec = {sByte, data[0]}; end
        endcase
        return v;
    endfunction

    VecT vecs[9];

    initial begin
        VecT        v;
        logic [7:0] modelRx;

        vecs[0] = '{INSTR_START, 8'h00, 8'hFF, 1'b1, 1'b0, 0,  8'h00, 9,  1'b0, 0, 9'h000};
        vecs[1] = '{INSTR_WRITE, 8'hA5, 8'hFF, 1'b0, 1'b0, 0,  8'h00, 73, 1'b0, 9, 9'h14A};
        vecs[2] = '{INSTR_WRITE, 8'hA5, 8'hFF, 1'b1, 1'b0, 0,  8'h01, 73, 1'b0, 9, 9'h14B};
        vecs[3] = '{INSTR_READ,  8'h00, 8'h3C, 1'b1, 1'b0, 0,  8'h3C, 73, 1'b0, 9, 9'h078};
        vecs[4] = '{INSTR_READ,  8'h01, 8'h3C, 1'b1, 1'b0, 0,  8'h3C, 73, 1'b0, 9, 9'h079};
        vecs[5] = '{INSTR_STOP,  8'h00, 8'hFF, 1'b1, 1'b0, 0,  8'h3C, 13, 1'b1, 1, 9'h000};
        vecs[6] = '{INSTR_START, 8'h00, 8'hFF, 1'b1, 1'b0, 10, 8'h3C, 9,  1'b0, 0, 9'h000};
        vecs[7] = '{INSTR_READ,  8'hFF, 8'h81, 1'b1, 1'b1, 0,  8'h81, 73, 1'b0, 9, 9'h103};
        vecs[8] = '{INSTR_STOP,  8'h00, 8'hFF, 1'b1, 1'b0, 0,  8'h81, 13, 1'b1, 1, 9'h000};

        bus.enable      = 1'b0;
        bus.instruction = INSTR_START;
        bus.byteToSend  = 8'h00;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetOutputs", {bus.scl, bus.isSending, bus.sdaOut, bus.complete, bus.byteReceived}, 12'hA00);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) runAndCheck(vecs[i], $sformatf("vec%0d", i));

        modelRx = 8'h81;
        v = modelOp(INSTR_START, 8'h00, 8'hFF, 1'b1, modelRx);
        runAndCheck(v, "rndStart");
        for (int i = 0; i < 12; i++) begin
            v = modelOp(InstrT'(2'($urandom_range(2, 3))), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), modelRx);
            runAndCheck(v, $sformatf("rnd%0d", i));
            modelRx = v.expRx;
        end
        v = modelOp(INSTR_READ, 8'h00, 8'hC3, 1'b1, modelRx);
        runAndCheck(v, "preResetRead");

        // Reset in the middle of a WRITE must release the bus on the next edge.
        slaveOp = INSTR_WRITE; slaveAck = 1'b0; fallBase = fallCount; slaveActive = 1'b1;
        bus.instruction = INSTR_WRITE;
        bus.byteToSend  = 8'h5A;
        bus.enable      = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        allowEdge = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midWriteReset", {bus.scl, bus.isSending, bus.sdaOut, bus.complete, bus.byteReceived}, 12'hA00);
        bus.enable  = 1'b0;
        slaveActive = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idleAfterReset", {bus.scl, bus.complete}, 2'b10);
        allowEdge = 1'b0;

        v = modelOp(INSTR_START, 8'h00, 8'hFF, 1'b1, 8'h00);
        runAndCheck(v, "postResetStart");
        v = modelOp(INSTR_STOP, 8'h00, 8'hFF, 1'b1, 8'h00);
        runAndCheck(v, "postResetStop");

        checkOutput("sdaStableWhileSclHigh", violations, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
